// File: rtl/psum_mem_arbiter_if.sv
// Requester-side bus of the partial-sum memory arbiter: two request channels
// plus their read-response channels.
interface psum_mem_arbiter_if #(
  parameter int LOG2_OF_MEM_HEIGHT = 8,
  parameter int DATA_WIDTH         = 32
);
  logic                          req0_valid;
  logic                          req0_ready;
  logic                          req0_we;
  logic                          req0_lock;
  logic [LOG2_OF_MEM_HEIGHT-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]         req0_wdata;
  logic                          rsp0_valid;
  logic [DATA_WIDTH-1:0]         rsp0_rdata;

  logic                          req1_valid;
  logic                          req1_ready;
  logic                          req1_we;
  logic                          req1_lock;
  logic [LOG2_OF_MEM_HEIGHT-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]         req1_wdata;
  logic                          rsp1_valid;
  logic [DATA_WIDTH-1:0]         rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Two-requester round-robin arbiter with lockable ownership in front of a
// single-port-per-direction partial-sum memory; registered memory side.
module psum_mem_arbiter #(
  parameter int LOG2_OF_MEM_HEIGHT = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  psum_mem_arbiter_if.slave             bus,
  output logic                          mem_read_en,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0]         mem_qout,
  output logic                          mem_write_en,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;

  logic [1:0]                    valid, lock, we;
  logic [LOG2_OF_MEM_HEIGHT-1:0] addr  [2];
  logic [DATA_WIDTH-1:0]         wdata [2];

  logic [1:0] ready, beat;
  logic       owned, own_idx, sel;

  logic       s1_valid, s1_owner;
  logic [1:0] rsp_valid;

  assign valid    = {bus.req1_valid, bus.req0_valid};
  assign lock     = {bus.req1_lock,  bus.req0_lock};
  assign we       = {bus.req1_we,    bus.req0_we};
  assign addr[0]  = bus.req0_addr;
  assign addr[1]  = bus.req1_addr;
  assign wdata[0] = bus.req0_wdata;
  assign wdata[1] = bus.req1_wdata;

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_rdata = mem_qout;
  assign bus.rsp1_rdata = mem_qout;

  // An owner that is neither valid nor locking releases the bus combinationally,
  // so the fall-through to round-robin happens in the same cycle.
  always_comb begin
    ready          = '0;
    sel            = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owned          = (state == OWN0) || (state == OWN1);
    own_idx        = (state == OWN1);

    if (owned && (valid[own_idx] || lock[own_idx])) ready[own_idx] = 1'b1;
    else if (valid == 2'b11)                         ready[~last_grant] = 1'b1;
    else if (valid[0])                               ready[0] = 1'b1;
    else if (valid[1])                               ready[1] = 1'b1;

    if (!arst_n_in) ready = '0;
    beat = ready & valid;

    if (beat != '0) begin
      sel            = beat[1];
      last_grant_nxt = sel;
      state_nxt      = !lock[sel] ? FREE : (sel ? OWN1 : OWN0);
    end else if (owned && !valid[own_idx] && !lock[own_idx]) begin
      state_nxt = FREE;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= FREE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      mem_din        <= '0;
      s1_valid       <= 1'b0;
      s1_owner       <= 1'b0;
      rsp_valid      <= '0;
      conflict_cnt   <= '0;
    end else begin
      mem_read_en  <= (beat != '0) && !we[sel];
      mem_write_en <= (beat != '0) &&  we[sel];
      if (beat != '0) begin
        if (we[sel]) begin
          mem_write_addr <= addr[sel];
          mem_din        <= wdata[sel];
        end else begin
          mem_read_addr  <= addr[sel];
        end
      end
      // Owner travels alongside the read so alternating reads route correctly.
      s1_valid     <= (beat != '0) && !we[sel];
      s1_owner     <= sel;
      rsp_valid[0] <= s1_valid && !s1_owner;
      rsp_valid[1] <= s1_valid &&  s1_owner;
      if (valid == 2'b11 && state == FREE && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Randomised and directed checking of psum_mem_arbiter against a transaction-level
// model (ownership, round-robin, timestamped response queue, reference memory).
module tb_psum_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic arst_n_in;
  always #5 clk = ~clk;

  psum_mem_arbiter_if #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW)) bus ();
  psum_mem_arbiter_if #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW)) bus4 ();

  logic          mem_read_en, mem_write_en;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [DW-1:0] mem_din, mem_qout;
  logic [15:0]   conflict_cnt;

  logic          mem4_read_en, mem4_write_en;
  logic [AW-1:0] mem4_read_addr, mem4_write_addr;
  logic [DW-1:0] mem4_din;
  logic [3:0]    conflict_cnt4;

  assign bus4.req0_valid = bus.req0_valid;
  assign bus4.req0_we    = bus.req0_we;
  assign bus4.req0_lock  = bus.req0_lock;
  assign bus4.req0_addr  = bus.req0_addr;
  assign bus4.req0_wdata = bus.req0_wdata;
  assign bus4.req1_valid = bus.req1_valid;
  assign bus4.req1_we    = bus.req1_we;
  assign bus4.req1_lock  = bus.req1_lock;
  assign bus4.req1_addr  = bus.req1_addr;
  assign bus4.req1_wdata = bus.req1_wdata;

  psum_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .bus(bus),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_qout(mem_qout),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_din(mem_din),
    .conflict_cnt(conflict_cnt)
  );

  psum_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .arst_n_in(arst_n_in), .bus(bus4),
    .mem_read_en(mem4_read_en), .mem_read_addr(mem4_read_addr), .mem_qout(mem_qout),
    .mem_write_en(mem4_write_en), .mem_write_addr(mem4_write_addr), .mem_din(mem4_din),
    .conflict_cnt(conflict_cnt4)
  );

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Synchronous memory: registered read, one-cycle latency.
  logic [31:0]  ram [256];
  logic [255:0] wr_seen = '0;
  always @(posedge clk) begin
    if (mem_write_en) begin
      ram[mem_write_addr]     <= mem_din;
      wr_seen[mem_write_addr] <= 1'b1;
    end
    if (mem_read_en)
      mem_qout <= wr_seen[mem_read_addr] ? ram[mem_read_addr] : init_val(int'(mem_read_addr));
  end

  typedef struct {
    int          due;
    int          who;
    logic [31:0] data;
  } rsp_t;

  int          nchk = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          m_owner, m_last, m_cnt, m_cnt4;
  logic [31:0] m_mem [256];
  logic        e_ren, e_wen;
  logic [7:0]  e_raddr, e_waddr;
  logic [31:0] e_din;
  rsp_t        rq [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_cnt4  = 0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_raddr = '0;
    e_waddr = '0;
    e_din   = '0;
    rq.delete();
  endtask

  task automatic drive(int i, logic v, logic w, logic lk, logic [7:0] a, logic [31:0] d);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_we = w; bus.req0_lock = lk;
      bus.req0_addr  = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = w; bus.req1_lock = lk;
      bus.req1_addr  = a; bus.req1_wdata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // Called just after a falling edge with inputs already applied: checks this
  // cycle's outputs against the model, then advances the model across the rising edge.
  task automatic tick();
    logic [1:0]  v, lk, w, er, ev;
    logic [7:0]  a [2];
    logic [31:0] d [2];
    logic [31:0] ed;
    int          eff, g;
    v    = {bus.req1_valid, bus.req0_valid};
    lk   = {bus.req1_lock,  bus.req0_lock};
    w    = {bus.req1_we,    bus.req0_we};
    a[0] = bus.req0_addr;  a[1] = bus.req1_addr;
    d[0] = bus.req0_wdata; d[1] = bus.req1_wdata;
    if (!arst_n_in) model_reset();
    #1;
    er  = '0;
    g   = -1;
    eff = m_owner;
    if (arst_n_in) begin
      if (eff >= 0 && !v[eff] && !lk[eff]) eff = -1;
      if (eff >= 0) begin
        er[eff] = 1'b1;
        if (v[eff]) g = eff;
      end else begin
        if (v == 2'b11) g = 1 - m_last;
        else if (v[0])  g = 0;
        else if (v[1])  g = 1;
        if (g >= 0) er[g] = 1'b1;
      end
    end
    ev = '0;
    ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev[rq[0].who] = 1'b1;
      ed = rq[0].data;
      void'(rq.pop_front());
    end
    chk("ready0", bus.req0_ready, er[0]);
    chk("ready1", bus.req1_ready, er[1]);
    chk("ready0_c4", bus4.req0_ready, er[0]);
    chk("ready1_c4", bus4.req1_ready, er[1]);
    chk("mem_read_en", mem_read_en, e_ren);
    chk("mem_write_en", mem_write_en, e_wen);
    chk("mem_read_addr", mem_read_addr, e_raddr);
    chk("mem_write_addr", mem_write_addr, e_waddr);
    chk("mem_din", mem_din, e_din);
    chk("mem_read_en_c4", mem4_read_en, e_ren);
    chk("mem_write_en_c4", mem4_write_en, e_wen);
    chk("mem_read_addr_c4", mem4_read_addr, e_raddr);
    chk("mem_write_addr_c4", mem4_write_addr, e_waddr);
    chk("mem_din_c4", mem4_din, e_din);
    chk("rsp0_valid", bus.rsp0_valid, ev[0]);
    chk("rsp1_valid", bus.rsp1_valid, ev[1]);
    chk("rsp0_valid_c4", bus4.rsp0_valid, ev[0]);
    chk("rsp1_valid_c4", bus4.rsp1_valid, ev[1]);
    if (ev[0]) chk("rsp0_rdata", bus.rsp0_rdata, ed);
    if (ev[1]) chk("rsp1_rdata", bus.rsp1_rdata, ed);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("conflict_cnt_c4", conflict_cnt4, m_cnt4);

    @(posedge clk);
    if (!arst_n_in) begin
      model_reset();
    end else begin
      if (v == 2'b11 && m_owner == -1) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      e_ren = 1'b0;
      e_wen = 1'b0;
      if (g >= 0) begin
        m_last  = g;
        m_owner = lk[g] ? g : -1;
        if (w[g]) begin
          e_wen = 1'b1; e_waddr = a[g]; e_din = d[g];
          m_mem[a[g]] = d[g];
        end else begin
          e_ren = 1'b1; e_raddr = a[g];
          rq.push_back('{due: cyc + 2, who: g, data: m_mem[a[g]]});
        end
      end else begin
        m_owner = eff;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    arst_n_in = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_read_en", mem_read_en, 1'b0);
    chk("reset_cnt", conflict_cnt, 16'd0);
    chk("reset_rsp0", bus.rsp0_valid, 1'b0);
    tick();
    tick();
    arst_n_in = 1'b1;

    // Tie: alternating grants, alternating addresses, counter every cycle.
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
      drive(1, 1'b1, 1'b0, 1'b0, 8'd9, 32'd0);
      #1;
      chk("tie_ready0", bus.req0_ready, (k % 2 == 0));
      chk("tie_ready1", bus.req1_ready, (k % 2 == 1));
      chk("tie_cnt", conflict_cnt, k);
      chk("sat_cnt4", conflict_cnt4, (k < 15) ? k : 15);
      if (k >= 1) chk("tie_raddr", mem_read_addr, (k % 2 == 1) ? 5 : 9);
      if (k >= 2) begin
        chk("tie_rsp0", bus.rsp0_valid, (k % 2 == 0));
        chk("tie_rsp1", bus.rsp1_valid, (k % 2 == 1));
      end
      tick();
    end
    idle();
    #1;
    chk("tie_cnt_end", conflict_cnt, 16'd20);
    chk("sat_hold", conflict_cnt4, 4'd15);
    tick();
    tick();

    // Lock: req0 holds the bus for four write beats while req1 waits.
    for (int k = 0; k < 5; k++) begin
      drive(0, (k < 4), 1'b1, (k < 3), 8'(20 + k), $urandom);
      drive(1, 1'b1, 1'b0, 1'b0, 8'd1, 32'd0);
      #1;
      chk("lock_ready0", bus.req0_ready, (k < 4));
      chk("lock_ready1", bus.req1_ready, (k == 4));
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Latency: single read of addr 3 by req1.
    drive(1, 1'b1, 1'b0, 1'b0, 8'd3, 32'd0);
    #1;
    chk("lat_ready1", bus.req1_ready, 1'b1);
    tick();
    idle();
    #1;
    chk("lat_ren_t1", mem_read_en, 1'b1);
    chk("lat_raddr_t1", mem_read_addr, 8'd3);
    chk("lat_rsp1_t1", bus.rsp1_valid, 1'b0);
    tick();
    #1;
    chk("lat_ren_t2", mem_read_en, 1'b0);
    chk("lat_rsp1_t2", bus.rsp1_valid, 1'b1);
    chk("lat_rsp0_t2", bus.rsp0_valid, 1'b0);
    chk("lat_rdata_t2", bus.rsp1_rdata, init_val(3));
    tick();
    #1;
    chk("lat_rsp1_t3", bus.rsp1_valid, 1'b0);
    tick();

    // Write then read the same address.
    drive(0, 1'b1, 1'b1, 1'b0, 8'd7, 32'hDEADBEEF);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'd7, 32'd0);
    tick();
    idle();
    tick();
    #1;
    chk("wtr_rsp0", bus.rsp0_valid, 1'b1);
    chk("wtr_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    tick();

    // Reset while a read sits in its memory stage.
    drive(1, 1'b1, 1'b0, 1'b0, 8'd4, 32'd0);
    tick();
    chk("rst_pre_ren", mem_read_en, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 8'd6, 32'd0);
    arst_n_in = 1'b0;
    #1;
    chk("rst_ren", mem_read_en, 1'b0);
    chk("rst_raddr", mem_read_addr, 8'd0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    tick();
    tick();
    idle();
    arst_n_in = 1'b1;
    tick();
    #1;
    chk("rst_no_rsp1", bus.rsp1_valid, 1'b0);
    tick();
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'd2, 32'd0);
    #1;
    chk("rel_ready0", bus.req0_ready, 1'b1);
    tick();
    idle();
    tick();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++)
        drive(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 15)), $urandom);
      arst_n_in = ($urandom_range(0, 499) != 0);
      tick();
      arst_n_in = 1'b1;
    end
    idle();
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/psum_mem_arbiter.md
PSUM_MEM_ARBITER -- requirements
Module: psum_mem_arbiter

Interface
REQ-001 SHALL have parameter LOG2_OF_MEM_HEIGHT, default 8, width of all memory addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of partial-sum data.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the conflict counter.
REQ-004 SHALL have ports clk (input, 1, sole clock) and arst_n_in (input, 1, reset, asynchronous, active-low).
REQ-005 SHALL have, for each requester i in {0,1}: req<i>_valid (input, 1, request pending), req<i>_ready (output, 1, request accepted this cycle), req<i>_we (input, 1, 1=write, 0=read), req<i>_lock (input, 1, keep ownership after this beat), req<i>_addr (input, LOG2_OF_MEM_HEIGHT), req<i>_wdata (input, DATA_WIDTH).
REQ-006 SHALL have, for each requester i: rsp<i>_valid (output, 1, read data valid) and rsp<i>_rdata (output, DATA_WIDTH, read data).
REQ-007 SHALL have memory ports mem_read_en (output, 1), mem_read_addr (output, LOG2_OF_MEM_HEIGHT), mem_qout (input, DATA_WIDTH), mem_write_en (output, 1), mem_write_addr (output, LOG2_OF_MEM_HEIGHT) and mem_din (output, DATA_WIDTH).
REQ-008 SHALL have conflict_cnt (output, CNT_WIDTH), which counts contention cycles.

Function
REQ-009 SHALL accept at most one request per cycle; req<i>_ready is combinational, and a beat transfers when req<i>_valid and req<i>_ready are both high.
REQ-010 SHALL hold ownership state in {FREE, OWN0, OWN1} and a registered round-robin pointer last_grant (0 or 1).
REQ-011 In FREE with one requester valid, it SHALL grant that requester.
REQ-012 In FREE with both requesters valid, it SHALL grant the requester that is not last_grant.
REQ-013 On every accepted beat, last_grant SHALL update to the granted index.
REQ-014 An accepted beat with req<i>_lock=1 SHALL move the state to OWN<i>.
REQ-015 An accepted beat with req<i>_lock=0 SHALL move the state to FREE.
REQ-016 In OWN<i>, only requester i SHALL be grantable, even if it is not valid.
REQ-017 In OWN<i>, if req<i>_valid=0 and req<i>_lock=0, the state SHALL return to FREE in the same cycle and the other requester SHALL be grantable that cycle.
REQ-018 Memory outputs SHALL be registered: an accepted beat at cycle t SHALL drive mem_*_en, addr and mem_din at cycle t+1, high for exactly one cycle.
REQ-019 Only one of mem_read_en and mem_write_en SHALL be high in any cycle; with no accepted beat, both SHALL be 0.
REQ-020 mem_qout SHALL be valid one cycle after mem_read_en; rsp<i>_valid SHALL pulse at t+2 for the owner of a read accepted at t, and rsp<i>_rdata SHALL equal mem_qout.
REQ-021 The response owner SHALL be tracked in a 2-stage pipeline, so back-to-back reads from alternating requesters route correctly.
REQ-022 rsp<j>_valid SHALL be 0 for every non-owner j.
REQ-023 rsp<i>_rdata SHALL be don't-care when rsp<i>_valid=0.
REQ-024 Writes SHALL produce no response.
REQ-025 conflict_cnt SHALL increment by 1 in each cycle where both req0_valid and req1_valid are high and the state is FREE.
REQ-026 conflict_cnt SHALL saturate at 2^CNT_WIDTH-1 and SHALL not wrap.
REQ-027 A write at t followed by a read of the same address at t+1 SHALL return the written data; the arbiter SHALL guarantee this by memory ordering alone, with no bypass.

Reset
REQ-028 On arst_n_in low, the block SHALL asynchronously set: state=FREE, last_grant=1 (so requester 0 wins the first tie), all mem enables=0, mem addresses and mem_din=0, rsp valids=0, response pipeline empty, conflict_cnt=0.
REQ-029 req<i>_ready SHALL be 0 while arst_n_in is low.
REQ-030 A reset asserted mid-transaction SHALL discard all in-flight reads; no rsp_valid SHALL appear after reset release for beats accepted before reset.
REQ-031 After release, the first grant SHALL be possible on the first rising edge where arst_n_in is high.

Verification
REQ-032 Tie test: after reset, both requesters issue reads to addr 5 (req0) and 9 (req1) continuously -> grants alternate 0,1,0,1; mem_read_addr sequence is 5,9,5,9; rsp0/rsp1 each pulse every other cycle with correct data; conflict_cnt increments every cycle.
REQ-033 Lock test: req0 issues 4 write beats with lock=1 on the first 3 and lock=0 on the last, while req1 is valid throughout -> req1_ready stays 0 for those 4 beats and is granted on the next cycle.
REQ-034 Latency test: single read by req1 of addr 3 accepted at cycle t -> mem_read_en high at t+1 only; rsp1_valid high at t+2 only, with rsp1_rdata = mem_qout; rsp0_valid stays 0.
REQ-035 Write-then-read test: req0 writes 0xDEADBEEF to addr 7, then reads addr 7 -> rsp0_rdata = 0xDEADBEEF two cycles after the read is accepted.
REQ-036 Saturation test: CNT_WIDTH=4 with both requesters valid for 20 cycles -> conflict_cnt stops at 15 and stays there.
REQ-037 Reset test: assert arst_n_in while a read is in its t+1 stage -> all outputs return to reset values immediately, and no rsp_valid appears after release.
